// File: rtl/mul_iter.sv
// mul_iter: iterative 32x32->64 multiplier answering a go/done handshake.
//
// The initiator raises go with stable operands and waits for done. The block
// latches the request (operands + signs) as a tag, converts both operands to
// magnitudes, retires STEP multiplier bits per cycle into an unsigned 64-bit
// accumulator and applies the sign at the end. done is asserted only while the
// live request still matches the latched tag, so the initiator can hold the
// same request indefinitely and an operand change silently restarts the work.
//
// Parameters:
//   STEP     multiplier bits retired per cycle (1,2,4,8,16,32); N = 32/STEP
// Ports:
//   clk_core in   core clock
//   reset_n  in   synchronous active-low reset
//   go       in   request valid, held until done is consumed
//   sign0    in   r is two's complement when 1
//   sign1    in   m is two's complement when 1
//   m        in   multiplicand [31:0]
//   r        in   multiplier [31:0]
//   done     out  result valid for the current request
//   result   out  64-bit product
module mul_iter #(
  parameter int STEP = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        go,
  input  logic        sign0,
  input  logic        sign1,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic        done,
  output logic [63:0] result
);

  localparam int N = 32 / STEP;
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic        load, accumulate, finish;
  logic        tag_match;

  logic [31:0] tag_m_reg, tag_r_reg;
  logic        tag_s0_reg, tag_s1_reg;
  logic [31:0] m_mag_reg, r_mag_reg;
  logic        neg_reg;
  logic [63:0] acc_reg;
  logic [5:0]  count_reg;
  logic [63:0] result_reg;

  logic [31:0] m_abs, r_abs;
  logic [63:0] row [STEP];
  logic [63:0] partial;
  logic [5:0]  shamt;
  logic [63:0] acc_sum;

  assign tag_match = (m == tag_m_reg) && (r == tag_r_reg) &&
                     (sign0 == tag_s0_reg) && (sign1 == tag_s1_reg);

  // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
  assign m_abs = (sign1 && m[31]) ? -m : m;
  assign r_abs = (sign0 && r[31]) ? -r : r;

  // One shifted copy of |m| per multiplier bit retired this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_row
      assign row[gi] = r_mag_reg[gi] ? ({32'b0, m_mag_reg} << gi) : 64'b0;
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      partial = partial + row[i];
    end
  end

  assign shamt   = 6'(32'(count_reg) * 32'(STEP));
  // Includes this cycle's partial product so the final edge can commit directly.
  assign acc_sum = acc_reg + (partial << shamt);

  // State register
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and control strobes
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    accumulate = 1'b0;
    finish     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!go) begin
          state_next = IDLE;
        end else begin
          accumulate = 1'b1;
          if (count_reg == LAST) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!go) begin
          state_next = IDLE;
        end else if (tag_match) begin
          done = 1'b1;
        end else begin
          // Request changed under us: treat it as a fresh request.
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      tag_m_reg  <= '0;
      tag_r_reg  <= '0;
      tag_s0_reg <= 1'b0;
      tag_s1_reg <= 1'b0;
      m_mag_reg  <= '0;
      r_mag_reg  <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      if (load) begin
        tag_m_reg  <= m;
        tag_r_reg  <= r;
        tag_s0_reg <= sign0;
        tag_s1_reg <= sign1;
        m_mag_reg  <= m_abs;
        r_mag_reg  <= r_abs;
        neg_reg    <= (sign1 & m[31]) ^ (sign0 & r[31]);
        acc_reg    <= '0;
        count_reg  <= '0;
      end else if (accumulate) begin
        acc_reg   <= acc_sum;
        // Widened so that STEP=32 shifts cleanly to zero.
        r_mag_reg <= 32'({32'b0, r_mag_reg} >> STEP);
        count_reg <= count_reg + 6'd1;
      end
      if (finish) begin
        result_reg <= neg_reg ? -acc_sum : acc_sum;
      end
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed and randomized checks of mul_iter. Five instances
// (STEP = 4, 1, 2, 8, 32) share one stimulus; directed handshake scenarios
// are checked on the STEP=4 instance, the random sweep on all of them.
module tb_mul_iter;

  logic        clk_core = 1'b0;
  logic        reset_n  = 1'b0;
  logic        go       = 1'b0;
  logic        sign0    = 1'b0;
  logic        sign1    = 1'b0;
  logic [31:0] m        = '0;
  logic [31:0] r        = '0;
  logic [4:0]  done_v;
  logic [63:0] res_v [5];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_core = ~clk_core;

  mul_iter #(.STEP(4)) u_s4 (
    .clk_core(clk_core), .reset_n(reset_n), .go(go), .sign0(sign0), .sign1(sign1),
    .m(m), .r(r), .done(done_v[0]), .result(res_v[0]));
  mul_iter #(.STEP(1)) u_s1 (
    .clk_core(clk_core), .reset_n(reset_n), .go(go), .sign0(sign0), .sign1(sign1),
    .m(m), .r(r), .done(done_v[1]), .result(res_v[1]));
  mul_iter #(.STEP(2)) u_s2 (
    .clk_core(clk_core), .reset_n(reset_n), .go(go), .sign0(sign0), .sign1(sign1),
    .m(m), .r(r), .done(done_v[2]), .result(res_v[2]));
  mul_iter #(.STEP(8)) u_s8 (
    .clk_core(clk_core), .reset_n(reset_n), .go(go), .sign0(sign0), .sign1(sign1),
    .m(m), .r(r), .done(done_v[3]), .result(res_v[3]));
  mul_iter #(.STEP(32)) u_s32 (
    .clk_core(clk_core), .reset_n(reset_n), .go(go), .sign0(sign0), .sign1(sign1),
    .m(m), .r(r), .done(done_v[4]), .result(res_v[4]));

  function automatic int step_of(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      default: return 32;
    endcase
  endfunction

  // Reference: sign- or zero-extend to 64 bits and multiply; the low 64 bits
  // of that product are the exact two's complement result.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s0, input logic s1);
    logic [63:0] x, y;
    x = s1 ? {{32{a[31]}}, a} : {32'b0, a};
    y = s0 ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic drive(input logic [31:0] mm, input logic [31:0] rr,
                       input logic s0, input logic s1);
    m = mm; r = rr; sign0 = s0; sign1 = s1; go = 1'b1;
  endtask

  // Drive a request and check the STEP=4 instance: done low for 9 cycles
  // (offsets 0..8), then done high with the expected product at offset 9.
  task automatic run_req(input string tag, input logic [31:0] mm, input logic [31:0] rr,
                         input logic s0, input logic s1, input logic [63:0] exp);
    drive(mm, rr, s0, s1);
    for (int k = 0; k <= 8; k++) begin
      #1;
      chk({tag, "_done_low"}, 64'(done_v[0]), 64'd0);
      tick();
    end
    #1;
    chk({tag, "_done_high"}, 64'(done_v[0]), 64'd1);
    chk({tag, "_result"}, res_v[0], exp);
    $display("req %s m=%h r=%h s0=%0b s1=%0b result=%h", tag, mm, rr, s0, s1, res_v[0]);
  endtask

  initial begin
    logic [63:0] last_res;
    logic [31:0] mm, rr;
    logic        s0, s1;
    int          first [5];
    logic [63:0] got [5];

    // Reset
    tick();
    tick();
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset_done_s%0d", step_of(i)), 64'(done_v[i]), 64'd0);
      chk($sformatf("reset_result_s%0d", step_of(i)), res_v[i], 64'd0);
    end
    reset_n = 1'b1;
    tick();

    // Signed -3 * 7
    run_req("neg3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    go = 1'b0; tick();

    // Unsigned and signed extremes
    run_req("umax_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    go = 1'b0; tick();
    run_req("smin_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    go = 1'b0; tick();

    // MULHSU: m signed, r unsigned
    run_req("mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001);
    last_res = 64'hFFFF_FFFF_0000_0001;

    // Hold the same request: done and result stay put
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("hold_done", 64'(done_v[0]), 64'd1);
      chk("hold_result", res_v[0], last_res);
    end
    tick();
    // Change m with go still high: immediate done drop, full restart
    run_req("restart", 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b1,
            ref_mul(32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b1));
    last_res = ref_mul(32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b1);
    go = 1'b0; tick();

    // Abort mid-BUSY by dropping go
    drive(32'd1234, 32'd5678, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("abort_busy_done", 64'(done_v[0]), 64'd0);
      tick();
    end
    go = 1'b0;
    #1;
    chk("abort_drop_done", 64'(done_v[0]), 64'd0);
    tick();
    #1;
    chk("abort_idle_done", 64'(done_v[0]), 64'd0);
    chk("abort_result_kept", res_v[0], last_res);
    $display("abort result=%h", res_v[0]);
    tick();
    run_req("after_abort", 32'd1234, 32'd5678, 1'b0, 1'b0, 64'd7006652);
    go = 1'b0; tick();

    // Reset mid-BUSY
    drive(32'd99, 32'd101, 1'b0, 1'b0);
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    #1;
    chk("midreset_done", 64'(done_v[0]), 64'd0);
    chk("midreset_result", res_v[0], 64'd0);
    $display("midreset done=%0b result=%h", done_v[0], res_v[0]);
    reset_n = 1'b1;
    go = 1'b0;
    tick();

    // Randomized sweep over every STEP: latency N+1 and product
    for (int it = 0; it < 10; it++) begin
      if (it == 0) begin
        mm = 32'd0; rr = 32'hFFFF_FFFB; s0 = 1'b1; s1 = 1'b0;
      end else if (it == 1) begin
        mm = 32'h8000_0000; rr = 32'h7FFF_FFFF; s0 = 1'b1; s1 = 1'b1;
      end else begin
        mm = $urandom; rr = $urandom;
        s0 = 1'($urandom_range(0, 1)); s1 = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 5; i++) begin
        first[i] = -1;
        got[i]   = '0;
      end
      drive(mm, rr, s0, s1);
      for (int k = 0; k <= 35; k++) begin
        #1;
        for (int i = 0; i < 5; i++) begin
          if (done_v[i] && first[i] < 0) begin
            first[i] = k;
            got[i]   = res_v[i];
          end
        end
        tick();
      end
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("sweep%0d_latency_s%0d", it, step_of(i)), 64'(first[i]),
            64'(32 / step_of(i) + 1));
        chk($sformatf("sweep%0d_result_s%0d", it, step_of(i)), got[i], ref_mul(mm, rr, s0, s1));
      end
      $display("sweep %0d m=%h r=%h s0=%0b s1=%0b ref=%h", it, mm, rr, s0, s1,
               ref_mul(mm, rr, s0, s1));
      go = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
